ps2_rx: RTL and testbench
=========================

PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive identical synchronized samples required before the filtered ps2_clk level changes.
REQ-002 Parameter TIMEOUT, default 25000: clk cycles without a filtered falling edge that abort a partial frame (1 ms at 25 MHz).
REQ-003 clk  input  1  system clock, rising edge, 25 MHz VGA clock domain.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-006 ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous to clk.
REQ-007 scancode  output  8  last completed non-prefix scancode byte.
REQ-008 extended  output  1  an E0 prefix preceded scancode.
REQ-009 released  output  1  an F0 prefix preceded scancode.
REQ-010 code_valid  output  1  single-cycle strobe; scancode, extended and released are valid this cycle.
REQ-011 frame_err  output  1  single-cycle strobe on a bad start bit, stop bit, parity or timeout.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any other use.
REQ-013 The filtered clock SHALL change level only after FILTER_LEN consecutive equal synchronized samples; it resets to 1.
REQ-014 Bit sampling SHALL occur only on the clk cycle that detects a filtered 1->0 transition, using the synchronized ps2_data.
REQ-015 The frame FSM SHALL have states IDLE, DATA, PARITY and STOP, with a 3-bit bit counter.
REQ-016 IDLE: sampled 0 -> DATA, counter=0; sampled 1 -> stay in IDLE and pulse frame_err.
REQ-017 DATA: shift the sample into bit[counter] (LSB first); counter=7 -> PARITY, else counter+1.
REQ-018 PARITY: store the sample; -> STOP.
REQ-019 STOP: the byte is good only if the sample is 1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity).
REQ-020 STOP, bad byte: pulse frame_err and clear the pending prefix flags.
REQ-021 STOP, all cases: return to IDLE.
REQ-022 A timeout counter SHALL reset on every sampling edge and count in any state other than IDLE.
REQ-023 On reaching TIMEOUT, the FSM SHALL go to IDLE, pulse frame_err, clear the prefix flags and discard the partial byte.
REQ-024 Good byte 0xE0: set the pending ext flag; no code_valid.
REQ-025 Good byte 0xF0: set the pending rel flag; no code_valid.
REQ-026 Any other good byte: on the next clk after the stop-bit sampling cycle, scancode=byte, extended=ext, released=rel, code_valid=1 for one cycle, then ext and rel clear.
REQ-027 Repeated prefixes (E0 E0, F0 F0) SHALL be idempotent, and flags SHALL accumulate across E0 F0 in either order.
REQ-028 scancode, extended and released SHALL hold their values between strobes.
REQ-029 code_valid and frame_err SHALL never be asserted in the same cycle.
REQ-030 Frames SHALL be processed back-to-back with no dead time beyond the stop bit.
REQ-031 No output SHALL depend combinationally on the ps2 inputs.

Reset
REQ-032 While reset_n=0: the FSM is IDLE, and counters, flags, scancode, extended, released, code_valid, frame_err and shift register are all 0.
REQ-033 While reset_n=0: synchronizer and filter flops are 1.
REQ-034 Reset deasserted mid-frame SHALL discard the frame; the next start bit begins cleanly.
REQ-035 reset_n SHALL assert asynchronously; deassertion need not be synchronized inside the block (it is done upstream).

Verification
REQ-036 Frame 0x1C, odd parity 0, stop 1, at a 12.5 kHz PS/2 clock -> one code_valid with scancode=0x1C, extended=0, released=0; frame_err never set.
REQ-037 Frames F0 then 1C -> single code_valid, scancode=0x1C, released=1, extended=0; a following 1C frame gives released=0.
REQ-038 Frames E0 F0 75 -> single code_valid, scancode=0x75, extended=1, released=1.
REQ-039 Frame 0x1C with the parity bit flipped -> frame_err for one cycle, no code_valid; the next good frame 0x32 gives scancode=0x32.
REQ-040 Stop after 4 data bits for more than 25000 cycles -> frame_err exactly once at the timeout, FSM back in IDLE; the next good frame decodes correctly.
REQ-041 ps2_clk glitch low for 5 clk cycles (fewer than FILTER_LEN) mid-frame -> no extra bit sampled; the frame decodes correctly.

Source files
------------

// File: rtl/ps2_rx_if.sv
// PS/2 receiver bundle: raw keyboard pins plus the decoded scancode stream.
// master = the receiver (reads the pins, drives the decoded outputs),
// slave  = the keyboard/consumer side (drives the pins, reads the decode).
interface ps2_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scancode;
  logic       extended;
  logic       released;
  logic       code_valid;
  logic       frame_err;

  modport master (
    input  ps2_clk, ps2_data,
    output scancode, extended, released, code_valid, frame_err
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  scancode, extended, released, code_valid, frame_err
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the PS/2 clock, frames
// 11-bit words (start, 8 data LSB first, odd parity, stop), folds E0/F0
// prefixes into extended/released flags and strobes one decoded scancode.
module ps2_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 25000
) (
  input  logic     clk,
  input  logic     reset_n,
  ps2_rx_if.master bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Synchronizer and filter state (idle-high line, so these reset to 1)
  logic          clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;

  // Frame state
  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          ext_q, ext_d;
  logic          rel_q, rel_d;

  // Registered outputs
  logic [7:0]    sc_q, sc_d;
  logic          exo_q, exo_d;
  logic          rlo_q, rlo_d;
  logic          cv_q, cv_d;
  logic          fe_q, fe_d;

  logic          sample_en;
  logic          bit_s;

  // Two-flop synchronizers on both raw PS/2 lines
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      clk_s1_q  <= bus.ps2_clk;
      clk_s2_q  <= clk_s1_q;
      data_s1_q <= bus.ps2_data;
      data_s2_q <= data_s1_q;
    end
  end

  // Glitch filter: flip the clean clock after FILTER_LEN differing samples in a row
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  // Sample data on the cycle the filtered clock is decided to fall
  assign sample_en = filt_q & ~filt_d;
  assign bit_s     = data_s2_q;

  // Frame FSM, timeout watchdog and prefix tracking
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    ext_d    = ext_q;
    rel_d    = rel_q;
    sc_d     = sc_q;
    exo_d    = exo_q;
    rlo_d    = rlo_q;
    cv_d     = 1'b0;
    fe_d     = 1'b0;
    to_cnt_d = (state_q == S_IDLE) ? '0 : to_cnt_q + 1'b1;

    if (sample_en) begin
      to_cnt_d = '0;
      case (state_q)
        S_IDLE: begin
          if (!bit_s) begin
            state_d = S_DATA;
            cnt_d   = 3'd0;
            shift_d = 8'h00;
          end else begin
            fe_d = 1'b1;
          end
        end
        S_DATA: begin
          shift_d[cnt_q] = bit_s;
          if (cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        S_PARITY: begin
          par_d   = bit_s;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
          if (bit_s && (^{shift_q, par_q})) begin
            if (shift_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              rel_d = 1'b1;
            end else begin
              sc_d  = shift_q;
              exo_d = ext_q;
              rlo_d = rel_q;
              cv_d  = 1'b1;
              ext_d = 1'b0;
              rel_d = 1'b0;
            end
          end else begin
            fe_d  = 1'b1;
            ext_d = 1'b0;
            rel_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && to_cnt_q == TW'(TIMEOUT - 1)) begin
      // Keyboard went quiet mid-frame: drop everything collected so far
      state_d  = S_IDLE;
      cnt_d    = 3'd0;
      shift_d  = 8'h00;
      par_d    = 1'b0;
      ext_d    = 1'b0;
      rel_d    = 1'b0;
      fe_d     = 1'b1;
      to_cnt_d = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
      sc_q       <= 8'h00;
      exo_q      <= 1'b0;
      rlo_q      <= 1'b0;
      cv_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      ext_q      <= ext_d;
      rel_q      <= rel_d;
      sc_q       <= sc_d;
      exo_q      <= exo_d;
      rlo_q      <= rlo_d;
      cv_q       <= cv_d;
      fe_q       <= fe_d;
    end
  end

  assign bus.scancode   = sc_q;
  assign bus.extended   = exo_q;
  assign bus.released   = rlo_q;
  assign bus.code_valid = cv_q;
  assign bus.frame_err  = fe_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: drives whole PS/2 frames, predicts the decoded event
// stream at byte level (prefix flags, parity/stop validity, timeouts) and
// checks every strobe and the held outputs each cycle against that stream.
`timescale 1ns/1ps
module tb_ps2_rx;

  localparam int TIMEOUT = 25000;

  typedef struct {
    bit         is_err;
    logic [7:0] sc;
    bit         ext;
    bit         rel;
    int         earliest;
  } ev_t;

  logic clk;
  logic reset_n;
  ps2_rx_if bus ();

  ps2_rx #(.FILTER_LEN(8), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_fall = 0;
  ev_t  exp_q[$];
  ev_t  cur;
  bit   model_ext = 0;
  bit   model_rel = 0;
  logic [7:0] held_sc = 8'h00;
  bit   held_ext = 0;
  bit   held_rel = 0;

  initial clk = 1'b0;
  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-level model of what the receiver must report for one frame
  task automatic model_frame(input logic [7:0] b, input bit good);
    ev_t e;
    e.is_err = 0; e.sc = 8'h00; e.ext = 0; e.rel = 0; e.earliest = 0;
    if (!good) begin
      e.is_err = 1;
      exp_q.push_back(e);
      model_ext = 0;
      model_rel = 0;
    end else if (b == 8'hE0) begin
      model_ext = 1;
    end else if (b == 8'hF0) begin
      model_rel = 1;
    end else begin
      e.sc = b; e.ext = model_ext; e.rel = model_rel;
      exp_q.push_back(e);
      model_ext = 0;
      model_rel = 0;
    end
  endtask

  function automatic logic [10:0] make_bits(input logic [7:0] b, input bit flip_par, input bit stop);
    logic p;
    p = ~^b;
    if (flip_par) p = ~p;
    return {stop, p, b, 1'b0};
  endfunction

  // Drive nbits of a frame; glitch_bit >= 0 puts a 5-cycle low pulse in that bit's high phase
  task automatic send_frame(input logic [10:0] bits, input int nbits, input int half, input int glitch_bit);
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = bits[i];
      if (i == glitch_bit) begin
        repeat (7) @(posedge clk);
        bus.ps2_clk = 1'b0;
        repeat (5) @(posedge clk);
        bus.ps2_clk = 1'b1;
        repeat (half - 12) @(posedge clk);
      end else begin
        repeat (half) @(posedge clk);
      end
      bus.ps2_clk = 1'b0;
      last_fall = cyc;
      repeat (half) @(posedge clk);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int half);
    model_frame(b, 1'b1);
    send_frame(make_bits(b, 1'b0, 1'b1), 11, half, -1);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [7:0] sc, input bit ex, input bit rl);
    @(negedge clk);
    check_lit({name, "_scancode"}, {24'h0, bus.scancode}, {24'h0, sc});
    check_lit({name, "_extended"}, {31'h0, bus.extended}, {31'h0, ex});
    check_lit({name, "_released"}, {31'h0, bus.released}, {31'h0, rl});
  endtask

  // Asynchronous reset mid-cycle; the model forgets everything in flight
  task automatic do_reset();
    @(posedge clk);
    exp_q.delete();
    model_ext = 0; model_rel = 0;
    held_sc = 8'h00; held_ext = 0; held_rel = 0;
    #3 reset_n = 1'b0;
    #1;
    check_lit("async_rst_scancode", {24'h0, bus.scancode}, 32'h0);
    check_lit("async_rst_flags", {29'h0, bus.extended, bus.released, bus.code_valid | bus.frame_err}, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Every cycle out of reset: each strobe must match the next predicted event, outputs hold otherwise
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.code_valid || bus.frame_err) begin
        checks++;
        if (bus.code_valid && bus.frame_err) begin
          errors++;
          $display("FAIL both_strobes: code_valid=1 frame_err=1 at cycle %0d, required not both", cyc);
        end
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: code_valid=%0b frame_err=%0b sc=%02h at cycle %0d, required none", bus.code_valid, bus.frame_err, bus.scancode, cyc);
        end else begin
          cur = exp_q.pop_front();
          if (cur.is_err) begin
            $display("event frame_err at cycle %0d", cyc);
            if (!bus.frame_err || bus.code_valid) begin
              errors++;
              $display("FAIL strobe_kind: code_valid=%0b sc=%02h, required frame_err", bus.code_valid, bus.scancode);
            end
          end else begin
            $display("event code sc=%02h ext=%0b rel=%0b at cycle %0d", bus.scancode, bus.extended, bus.released, cyc);
            if (!bus.code_valid || bus.scancode !== cur.sc || bus.extended !== cur.ext || bus.released !== cur.rel) begin
              errors++;
              $display("FAIL code: cv=%0b sc=%02h ext=%0b rel=%0b, required cv=1 sc=%02h ext=%0b rel=%0b", bus.code_valid, bus.scancode, bus.extended, bus.released, cur.sc, cur.ext, cur.rel);
            end
            held_sc = cur.sc; held_ext = cur.ext; held_rel = cur.rel;
          end
          if (cyc < cur.earliest) begin
            errors++;
            $display("FAIL early_strobe: at cycle %0d, required not before %0d", cyc, cur.earliest);
          end
        end
      end
      checks++;
      if (bus.scancode !== held_sc || bus.extended !== held_ext || bus.released !== held_rel) begin
        errors++;
        $display("FAIL hold: sc=%02h ext=%0b rel=%0b at cycle %0d, required sc=%02h ext=%0b rel=%0b", bus.scancode, bus.extended, bus.released, cyc, held_sc, held_ext, held_rel);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    ev_t e;
    logic [7:0] b;
    int r, c, half;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    reset_n      = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_lit("reset_outs", {24'h0, bus.scancode}, 32'h0);
    check_lit("reset_strobes", {28'h0, bus.extended, bus.released, bus.code_valid, bus.frame_err}, 32'h0);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);

    // 0x1C at a 12.5 kHz PS/2 clock (2000 system clocks per bit)
    send_byte(8'h1C, 1000);
    wait_drain(200, "slow_1c");
    check_outs("slow_1c", 8'h1C, 0, 0);

    // Break code, then a plain make clears the released flag
    send_byte(8'hF0, 20);
    send_byte(8'h1C, 20);
    wait_drain(200, "f0_1c");
    check_outs("f0_1c", 8'h1C, 0, 1);
    send_byte(8'h1C, 20);
    wait_drain(200, "after_break");
    check_outs("after_break", 8'h1C, 0, 0);

    // Extended break
    send_byte(8'hE0, 20);
    send_byte(8'hF0, 20);
    send_byte(8'h75, 20);
    wait_drain(200, "e0_f0_75");
    check_outs("e0_f0_75", 8'h75, 1, 1);

    // Repeated prefixes in reversed order
    send_byte(8'hF0, 20);
    send_byte(8'hF0, 20);
    send_byte(8'hE0, 20);
    send_byte(8'hE0, 20);
    send_byte(8'h6B, 20);
    wait_drain(200, "f0f0e0e0_6b");
    check_outs("f0f0e0e0_6b", 8'h6B, 1, 1);

    // Parity error drops a pending prefix, next frame decodes normally
    send_byte(8'hE0, 20);
    model_frame(8'h1C, 1'b0);
    send_frame(make_bits(8'h1C, 1'b1, 1'b1), 11, 20, -1);
    send_byte(8'h32, 20);
    wait_drain(200, "parity_then_32");
    check_outs("parity_then_32", 8'h32, 0, 0);

    // Bad stop bit
    model_frame(8'h44, 1'b0);
    send_frame(make_bits(8'h44, 1'b0, 1'b0), 11, 20, -1);
    wait_drain(200, "bad_stop");

    // Lone falling edge with data high is a bad start bit; pending prefix survives it
    send_byte(8'hF0, 20);
    e.is_err = 1; e.sc = 8'h00; e.ext = 0; e.rel = 0; e.earliest = 0;
    exp_q.push_back(e);
    send_frame(11'h7FF, 1, 20, -1);
    send_byte(8'h29, 20);
    wait_drain(200, "bad_start");
    check_outs("bad_start", 8'h29, 0, 1);

    // Short clock glitch in the high phase of data bit 4
    model_frame(8'h5A, 1'b1);
    send_frame(make_bits(8'h5A, 1'b0, 1'b1), 11, 30, 5);
    wait_drain(200, "glitch_5a");
    check_outs("glitch_5a", 8'h5A, 0, 0);

    // Timeout after start + 4 data bits, with a pending break prefix
    send_byte(8'hF0, 20);
    send_frame(make_bits(8'h3C, 1'b0, 1'b1), 5, 20, -1);
    e.is_err = 1; e.sc = 8'h00; e.ext = 0; e.rel = 0; e.earliest = last_fall + TIMEOUT;
    exp_q.push_back(e);
    model_ext = 0; model_rel = 0;
    repeat (TIMEOUT + 100) @(posedge clk);
    wait_drain(200, "timeout");
    send_byte(8'h1C, 20);
    wait_drain(200, "after_timeout");
    check_outs("after_timeout", 8'h1C, 0, 0);

    // Reset in the middle of a frame, with a pending extended prefix
    send_byte(8'hE0, 20);
    send_frame(make_bits(8'h4D, 1'b0, 1'b1), 6, 20, -1);
    do_reset();
    repeat (5) @(posedge clk);
    send_byte(8'h4D, 20);
    wait_drain(200, "after_reset");
    check_outs("after_reset", 8'h4D, 0, 0);

    // Randomized back-to-back traffic with prefixes and corrupted frames
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      b = 8'hE0;
      else if (r == 1) b = 8'hF0;
      else             b = 8'($urandom);
      c = $urandom_range(0, 15);
      half = $urandom_range(15, 30);
      model_frame(b, (c > 1));
      send_frame(make_bits(b, (c == 0), (c != 1)), 11, half, -1);
      repeat ($urandom_range(0, 30)) @(posedge clk);
    end
    wait_drain(200, "random");

    repeat (10) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
